decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameter DEPTH, default 4, buffer entry count; SHALL be a power of two, >= 2.
REQ-002 Parameter BR_ID_W, default 3, width of the branch tag carried per instruction.
REQ-003 Parameter CNT_W, default 32, width of the retired-branch counter.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush_i  in  1  pipeline flush (mispredict/redirect).
REQ-007 fetch_valid  in  1  I-cache response beat present.
REQ-008 fetch_ready  out  1  buffer can accept a beat.
REQ-009 fetch_instr  in  32  raw instruction word.
REQ-010 fetch_pc  in  32  PC of fetch_instr.
REQ-011 fetch_br_id  in  BR_ID_W  branch tag for the beat.
REQ-012 out_valid  out  1  head entry is presentable to the instruction queue.
REQ-013 out_ready  in  1  instruction queue accepts the head entry.
REQ-014 out_instr / out_pc  out  32 each  head raw word and PC.
REQ-015 out_opcode 7, out_funct3 3, out_funct7 7, out_rs1 5, out_rs2 5, out_rd 5  out  decoded head fields.
REQ-016 out_i_imm / out_s_imm / out_b_imm / out_u_imm / out_j_imm  out  32 each  RV32I immediates, sign-extended.
REQ-017 out_br_id  out  BR_ID_W  head branch tag.
REQ-018 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-019 branch_count  out  CNT_W  number of dequeued br/jal/jalr instructions.

Function
REQ-020 Buffer SHALL be a circular FIFO of DEPTH entries {instr, pc, br_id}; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 fetch_ready SHALL equal (count < DEPTH); no same-cycle full bypass — a full buffer with a dequeue SHALL still deassert fetch_ready.
REQ-022 A beat is accepted when fetch_valid && fetch_ready; an accepted beat SHALL be written unless dropped per REQ-023.
REQ-023 An accepted beat SHALL be dropped (handshake completes, nothing written) when flush_i=1, flush_pend=1, or fetch_instr==32'h0.
REQ-024 flush_pend SHALL set on flush_i=1 with no accepted beat that cycle; clear on the next accepted beat; remain 0 when flush_i and an accepted beat coincide.
REQ-025 flush_i=1 SHALL empty the buffer at the next edge (count=0, pointers equal); a same-cycle dequeue or enqueue SHALL be discarded.
REQ-026 out_valid SHALL equal (count != 0) && !flush_i.
REQ-027 Dequeue occurs when out_valid && out_ready; head pointer advances by one.
REQ-028 Latency: a written beat SHALL be visible at the outputs no earlier than the cycle after acceptance; no empty-buffer bypass.
REQ-029 Simultaneous enqueue and dequeue (not full, not empty) SHALL leave count unchanged.
REQ-030 Decoded outputs SHALL be combinational from the head entry; values SHALL be don't-care when out_valid=0.
REQ-031 out_rd SHALL be 5'd0 when out_opcode is 7'b1100011 (branch) or 7'b0100011 (store), else instr[11:7].
REQ-032 Immediates SHALL follow RV32I encoding; b_imm and j_imm bit 0 SHALL be 0; u_imm low 12 bits SHALL be 0.
REQ-033 branch_count SHALL increment by 1 on each dequeue with opcode 1100011, 1101111 or 1100111; SHALL wrap at 2^CNT_W; SHALL not be affected by flush_i.

Reset
REQ-034 While rst=0: count=0, pointers=0, flush_pend=0, branch_count=0, out_valid=0, fetch_ready=0; after rst rises, fetch_ready=1 from the first edge on; entry contents are not reset.

Verification
REQ-035 Fill: 4 beats (instr 0x00500093 addi x1,x0,5, pc 0x100..0x10C), out_ready=0 -> count=4, fetch_ready=0; then out_ready=1 -> 4 dequeues in pc order, out_rd=1, out_i_imm=5.
REQ-036 Zero filter: fetch_instr=0 accepted -> count unchanged, fetch_ready stays 1.
REQ-037 Flush with 3 entries, flush_i pulse, no fetch -> out_valid=0 during flush cycle, count=0 next; next beat dropped; following beat stored (count=1).
REQ-038 Flush coincident with accepted beat -> beat dropped, flush_pend=0, next beat stored.
REQ-039 Dequeue beq (0xFE000EE3) and jal -> out_rd=0 for beq, out_b_imm=0xFFFFFFFC, branch_count=2.
REQ-040 Pointer wrap: 10 interleaved enqueue/dequeue with DEPTH=4 -> FIFO order preserved; rst=0 mid-stream -> count=0, out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_buffer_if.sv
// Fetch-side and instruction-queue-side handshake bundle for decode_buffer.
// The slave modport is the buffer; the master modport is its environment.
interface decode_buffer_if #(
  parameter int DEPTH   = 4,
  parameter int BR_ID_W = 3,
  parameter int CNT_W   = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               flush_i;
  logic               fetch_valid;
  logic               fetch_ready;
  logic [31:0]        fetch_instr;
  logic [31:0]        fetch_pc;
  logic [BR_ID_W-1:0] fetch_br_id;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic [6:0]         out_opcode;
  logic [2:0]         out_funct3;
  logic [6:0]         out_funct7;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [4:0]         out_rd;
  logic [31:0]        out_i_imm;
  logic [31:0]        out_s_imm;
  logic [31:0]        out_b_imm;
  logic [31:0]        out_u_imm;
  logic [31:0]        out_j_imm;
  logic [BR_ID_W-1:0] out_br_id;

  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   branch_count;

  modport slave (
    input  flush_i,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_br_id,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_opcode,
    output out_funct3,
    output out_funct7,
    output out_rs1,
    output out_rs2,
    output out_rd,
    output out_i_imm,
    output out_s_imm,
    output out_b_imm,
    output out_u_imm,
    output out_j_imm,
    output out_br_id,
    output count,
    output branch_count
  );

  modport master (
    output flush_i,
    output fetch_valid,
    input  fetch_ready,
    output fetch_instr,
    output fetch_pc,
    output fetch_br_id,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_opcode,
    input  out_funct3,
    input  out_funct7,
    input  out_rs1,
    input  out_rs2,
    input  out_rd,
    input  out_i_imm,
    input  out_s_imm,
    input  out_b_imm,
    input  out_u_imm,
    input  out_j_imm,
    input  out_br_id,
    input  count,
    input  branch_count
  );
endinterface

// File: rtl/decode_buffer.sv
// Fetch-to-decode circular buffer with RV32I field/immediate predecode
// of the head entry and a retired-branch counter.
module decode_buffer #(
  parameter int DEPTH   = 4,
  parameter int BR_ID_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  decode_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0]        instr;
    logic [31:0]        pc;
    logic [BR_ID_W-1:0] br_id;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             pend_q;
  logic             rdy_q;
  logic [CNT_W-1:0] brc_q;

  entry_t           head;
  entry_t           wdat;
  logic [31:0]      hi;
  logic             full;
  logic             accept;
  logic             wr;
  logic             rd;
  logic             is_br;
  logic             no_rd;

  assign full   = (count_q == CW'(DEPTH));
  assign accept = bus.fetch_valid && bus.fetch_ready;
  // Beats during or right after a flush belong to the squashed path.
  assign wr     = accept && !bus.flush_i && !pend_q
               && (bus.fetch_instr != 32'h0);
  assign rd     = bus.out_valid && bus.out_ready;

  assign bus.fetch_ready = rdy_q && !full;
  assign bus.out_valid   = (count_q != '0) && !bus.flush_i;

  assign wdat.instr = bus.fetch_instr;
  assign wdat.pc    = bus.fetch_pc;
  assign wdat.br_id = bus.fetch_br_id;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= wdat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
      brc_q   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (bus.flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        pend_q  <= !accept;
      end else begin
        if (accept) begin
          pend_q <= 1'b0;
        end
        if (wr) begin
          wptr_q <= wptr_q + PW'(1);
        end
        if (rd) begin
          rptr_q <= rptr_q + PW'(1);
        end
        count_q <= count_q + CW'(wr) - CW'(rd);
      end
      if (rd && is_br) begin
        brc_q <= brc_q + CNT_W'(1);
      end
    end
  end

  assign head = mem_q[rptr_q];
  assign hi   = head.instr;

  always_comb begin
    is_br = 1'b0;
    no_rd = 1'b0;
    unique case (hi[6:0])
      OP_BRANCH: begin
        is_br = 1'b1;
        no_rd = 1'b1;
      end
      OP_JAL, OP_JALR: is_br = 1'b1;
      OP_STORE:        no_rd = 1'b1;
      default: begin
        is_br = 1'b0;
        no_rd = 1'b0;
      end
    endcase
  end

  assign bus.out_instr  = hi;
  assign bus.out_pc     = head.pc;
  assign bus.out_br_id  = head.br_id;
  assign bus.out_opcode = hi[6:0];
  assign bus.out_funct3 = hi[14:12];
  assign bus.out_funct7 = hi[31:25];
  assign bus.out_rs1    = hi[19:15];
  assign bus.out_rs2    = hi[24:20];
  assign bus.out_rd     = no_rd ? 5'd0 : hi[11:7];

  assign bus.out_i_imm = {{20{hi[31]}}, hi[31:20]};
  assign bus.out_s_imm = {{20{hi[31]}}, hi[31:25], hi[11:7]};
  assign bus.out_b_imm = {{19{hi[31]}}, hi[31], hi[7],
                          hi[30:25], hi[11:8], 1'b0};
  assign bus.out_u_imm = {hi[31:12], 12'h000};
  assign bus.out_j_imm = {{11{hi[31]}}, hi[31], hi[19:12],
                          hi[20], hi[30:21], 1'b0};

  assign bus.count        = count_q;
  assign bus.branch_count = brc_q;
endmodule

// File: tb/tb_decode_buffer.sv
// Randomized bench for decode_buffer against a queue-based reference model.
// Directed sequences with literal expectations pin the model first.
module tb_decode_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  decode_buffer_if #(.DEPTH(DEPTH), .BR_ID_W(3), .CNT_W(32)) bus ();

  decode_buffer #(.DEPTH(DEPTH), .BR_ID_W(3), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  br;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  int unsigned m_bc;
  int          n_vec;
  int          n_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(logic [31:0] v, int bits);
    logic [31:0] m;
    m = 32'h1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  function automatic bit is_branchy(logic [31:0] ins);
    int op;
    op = ins & 32'h7F;
    return op == 'h63 || op == 'h6F || op == 'h67;
  endfunction

  task automatic chk_head(ent_t e);
    logic [31:0] i;
    int op;
    i  = e.instr;
    op = i & 32'h7F;
    chk("instr", bus.out_instr, i);
    chk("pc", bus.out_pc, e.pc);
    chk("br_id", 32'(bus.out_br_id), 32'(e.br));
    chk("opcode", 32'(bus.out_opcode), 32'(op));
    chk("funct3", 32'(bus.out_funct3), (i >> 12) & 7);
    chk("funct7", 32'(bus.out_funct7), i >> 25);
    chk("rs1", 32'(bus.out_rs1), (i >> 15) & 31);
    chk("rs2", 32'(bus.out_rs2), (i >> 20) & 31);
    chk("rd", 32'(bus.out_rd),
        (op == 'h63 || op == 'h23) ? 0 : (i >> 7) & 31);
    chk("i_imm", bus.out_i_imm, sx(i >> 20, 12));
    chk("s_imm", bus.out_s_imm,
        sx(((i >> 25) << 5) | ((i >> 7) & 31), 12));
    chk("b_imm", bus.out_b_imm,
        sx((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11)
           | (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13));
    chk("u_imm", bus.out_u_imm, i & 32'hFFFF_F000);
    chk("j_imm", bus.out_j_imm,
        sx((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12)
           | (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21));
  endtask

  // One clock: drive, compare against model, then advance the model.
  task automatic step(bit fv, logic [31:0] ins, logic [31:0] pc,
                      logic [2:0] br, bit fl, bit ordy);
    bit   acc;
    bit   ov;
    ent_t e;
    @(negedge clk);
    bus.fetch_valid = fv;
    bus.fetch_instr = ins;
    bus.fetch_pc    = pc;
    bus.fetch_br_id = br;
    bus.flush_i     = fl;
    bus.out_ready   = ordy;
    #1;
    ov  = (mq.size() != 0) && !fl;
    acc = fv && (mq.size() < DEPTH);
    chk("fetch_ready", 32'(bus.fetch_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    chk("count", 32'(bus.count), mq.size());
    chk("branch_count", bus.branch_count, m_bc);
    if (ov) chk_head(mq[0]);
    if (fl) begin
      mq.delete();
      m_pend = !acc;
    end else begin
      if (ov && ordy) begin
        if (is_branchy(mq[0].instr)) m_bc++;
        void'(mq.pop_front());
      end
      if (acc) begin
        if (!m_pend && ins != 0) begin
          e.instr = ins;
          e.pc    = pc;
          e.br    = br;
          mq.push_back(e);
        end
        m_pend = 0;
      end
    end
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = 32'h0;
    bus.fetch_pc    = 32'h0;
    bus.fetch_br_id = 3'd0;
    bus.flush_i     = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = 32'h0;
      1: r = (r & ~32'h7F) | 32'h63;
      2: r = (r & ~32'h7F) | 32'h6F;
      3: r = (r & ~32'h7F) | 32'h67;
      4: r = (r & ~32'h7F) | 32'h23;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'h0050_0093;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_pend = 0;
    m_bc   = 0;
    rst    = 1'b0;
    idle();
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = ADDI;
    bus.out_ready   = 1'b1;
    #3;
    chk("rst count", 32'(bus.count), 0);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst fetch_ready", 32'(bus.fetch_ready), 0);
    chk("rst branch_count", bus.branch_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b1;
    post();
    chk("post-rst fetch_ready", 32'(bus.fetch_ready), 1);

    // Fill, then drain in order.
    for (int i = 0; i < 4; i++) step(1, ADDI, 32'h100 + 4 * i, 3'(i), 0, 0);
    post();
    chk("fill count", 32'(bus.count), 4);
    chk("fill fetch_ready", 32'(bus.fetch_ready), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("drain pc", bus.out_pc, 32'h100 + 4 * i);
      chk("drain rd", 32'(bus.out_rd), 1);
      chk("drain i_imm", bus.out_i_imm, 5);
    end
    post();
    chk("drained count", 32'(bus.count), 0);

    // Zero words are swallowed.
    step(1, 32'h0, 32'h200, 0, 0, 0);
    post();
    chk("zero count", 32'(bus.count), 0);
    chk("zero fetch_ready", 32'(bus.fetch_ready), 1);

    // Flush with no fetch: next beat dropped, following one kept.
    for (int i = 0; i < 3; i++) step(1, ADDI, 32'h300 + 4 * i, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("flush out_valid", 32'(bus.out_valid), 0);
    post();
    chk("flush count", 32'(bus.count), 0);
    step(1, ADDI, 32'h400, 0, 0, 0);
    post();
    chk("pend drop count", 32'(bus.count), 0);
    step(1, ADDI, 32'h404, 0, 0, 0);
    post();
    chk("after pend count", 32'(bus.count), 1);
    step(0, 0, 0, 0, 0, 1);

    // Flush coinciding with an accepted beat leaves nothing pending.
    step(1, ADDI, 32'h500, 0, 1, 0);
    post();
    chk("flush+beat count", 32'(bus.count), 0);
    step(1, ADDI, 32'h504, 0, 0, 0);
    post();
    chk("no pend count", 32'(bus.count), 1);
    step(0, 0, 0, 0, 0, 1);

    // Branch retirement.
    step(1, 32'hFE00_0EE3, 32'h600, 3'd5, 0, 0);
    step(1, 32'h0080_00EF, 32'h604, 3'd6, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("beq rd", 32'(bus.out_rd), 0);
    chk("beq b_imm", bus.out_b_imm, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1);
    post();
    chk("branch_count", bus.branch_count, 2);

    // Pointer wrap with simultaneous enqueue/dequeue.
    for (int i = 0; i < 10; i++) step(1, ADDI + 32'(i << 20), 32'h700 + 4 * i, 3'(i), 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-stream.
    step(1, ADDI, 32'h800, 0, 0, 0);
    step(1, ADDI, 32'h804, 0, 0, 0);
    post();
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("async count", 32'(bus.count), 0);
    chk("async out_valid", 32'(bus.out_valid), 0);
    chk("async fetch_ready", 32'(bus.fetch_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_pend = 0;
    m_bc   = 0;
    post();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom,
           3'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
